// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Round-robin arbiter sharing one combinational ALU between N_REQ requesters.
//   A single operation is in flight at a time: accept (IDLE) -> drive ALU from
//   operand registers (EXEC) -> present registered result until consumed (RESP).
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req_valid / req_ready    per-requester handshake (req_ready is combinational, one-hot or zero)
//   req_a, req_b, req_op     packed per-requester operands; requester i at [W*i +: W]
//   alu_in_a/b, alu_control  registered drive to the shared ALU
//   alu_result, alu_zero     ALU outputs, sampled during EXEC
//   rsp_valid / rsp_ready    response handshake
//   rsp_id, rsp_result, rsp_zero, rsp_err   response payload (err = undefined op code)
// Configuration
//   ALU_ARB_STATS_EN         adds grant_cnt[16*N_REQ]: saturating per-requester accept counters
module alu_share_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    input  logic [4*N_REQ-1:0]   req_op,
    output logic [31:0]          alu_in_a,
    output logic [31:0]          alu_in_b,
    output logic [3:0]           alu_control,
    input  logic [31:0]          alu_result,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_err
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [16*N_REQ-1:0]  grant_cnt
`endif
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNT_W  = 16;
    localparam logic [OP_W-1:0] OP_MAX = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] op_id;
    logic [ID_W-1:0] win_idx;
    logic            win_found;
    logic            accept;
    int unsigned     pos;

    // Round-robin search: scan downward so the lowest offset from rr_ptr wins
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        pos       = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = 32'(rr_ptr) + 32'(k);
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (req_valid[ID_W'(pos)]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(pos);
            end
        end
    end

    // Grant only in IDLE and never while reset is asserted
    always_comb begin
        req_ready = '0;
        accept    = win_found && (state == S_IDLE) && !rst;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_RESP;
            S_RESP:  if (rsp_valid && rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, pointer advance and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            op_id       <= '0;
            alu_in_a    <= '0;
            alu_in_b    <= '0;
            alu_control <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            if (accept) begin
                alu_in_a    <= req_a[DATA_W*win_idx +: DATA_W];
                alu_in_b    <= req_b[DATA_W*win_idx +: DATA_W];
                alu_control <= req_op[OP_W*win_idx +: OP_W];
                op_id       <= win_idx;
                rr_ptr      <= (32'(win_idx) == N_REQ - 1) ? '0 : win_idx + ID_W'(1);
            end
            if (state == S_EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= op_id;
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_err    <= (alu_control > OP_MAX);
            end else if (state == S_RESP && rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Saturating per-requester accept counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (accept && (grant_cnt[CNT_W*win_idx +: CNT_W] != '1)) begin
            grant_cnt[CNT_W*win_idx +: CNT_W] <= grant_cnt[CNT_W*win_idx +: CNT_W] + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: transaction-level reference model, directed
// scenarios followed by randomized traffic. Build with +define+ALU_ARB_STATS_EN
// to also cover the grant counters.
module tb_alu_share_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_a = '0;
    logic [32*N-1:0]   req_b = '0;
    logic [4*N-1:0]    req_op = '0;
    logic [31:0]       alu_in_a;
    logic [31:0]       alu_in_b;
    logic [3:0]        alu_control;
    logic [31:0]       alu_result;
    logic              alu_zero;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_result;
    logic              rsp_zero;
    logic              rsp_err;
`ifdef ALU_ARB_STATS_EN
    logic [16*N-1:0]   grant_cnt;
`endif

    alu_share_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .alu_in_a    (alu_in_a),
        .alu_in_b    (alu_in_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_err     (rsp_err)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt   (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Shared ALU behaviour: {zero, result}
    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        logic [31:0] r;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: r = 32'($signed(a) >>> b[4:0]);
            4'd8: r = {31'd0, $signed(a) < $signed(b)};
            4'd9: r = {31'd0, a < b};
            default: return {1'b0, 32'hdeadbeef};
        endcase
        return {r == 32'd0, r};
    endfunction

    always_comb {alu_zero, alu_result} = alu_ref(alu_in_a, alu_in_b, alu_control);

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model state
    bit          m_pending = 0;
    int          m_acc = 0;
    int          m_id = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [3:0]  m_op = '0;
    int          m_ptr = 0;
    int          m_cnt [N];
    int          cyc = 0;
    int          grant_log [$];
    logic [31:0] seen_id, seen_res, seen_zero, seen_err;

    function automatic int pick(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_cnt();
`ifdef ALU_ARB_STATS_EN
        for (int i = 0; i < N; i++) check("grant_cnt", 32'(grant_cnt[16*i +: 16]), 32'(m_cnt[i]));
`endif
    endtask

    // One clock cycle: check at negedge against the model, then advance to posedge+1
    task automatic tick();
        int           w;
        logic [N-1:0] er;
        logic         rv;
        logic [32:0]  r;
        @(negedge clk);
        if (rst) begin
            m_pending = 0;
            m_ptr     = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_id", 32'(rsp_id), 32'd0);
            check("rst_rsp_result", rsp_result, 32'd0);
            check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
            check("rst_rsp_err", 32'(rsp_err), 32'd0);
            check("rst_alu_in_a", alu_in_a, 32'd0);
            check("rst_alu_in_b", alu_in_b, 32'd0);
            check("rst_alu_control", 32'(alu_control), 32'd0);
            check_cnt();
        end else begin
            check_cnt();
            w  = m_pending ? -1 : pick(m_ptr, req_valid);
            er = '0;
            if (w >= 0) er[w] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(er));
            rv = m_pending && (cyc >= m_acc + 2);
            check("rsp_valid", 32'(rsp_valid), 32'(rv));
            if (m_pending && cyc == m_acc + 1) begin
                check("alu_in_a", alu_in_a, m_a);
                check("alu_in_b", alu_in_b, m_b);
                check("alu_control", 32'(alu_control), 32'(m_op));
            end
            if (rv) begin
                r = alu_ref(m_a, m_b, m_op);
                check("rsp_id", 32'(rsp_id), 32'(m_id));
                check("rsp_result", rsp_result, r[31:0]);
                check("rsp_zero", 32'(rsp_zero), 32'(r[32]));
                check("rsp_err", 32'(rsp_err), 32'(m_op > 4'd9));
            end
            if (rsp_valid && rsp_ready) begin
                seen_id   = 32'(rsp_id);
                seen_res  = rsp_result;
                seen_zero = 32'(rsp_zero);
                seen_err  = 32'(rsp_err);
            end
            if (rv && rsp_ready) m_pending = 0;
            if (w >= 0) begin
                m_pending = 1;
                m_acc     = cyc;
                m_id      = w;
                m_a       = req_a[32*w +: 32];
                m_b       = req_b[32*w +: 32];
                m_op      = req_op[4*w +: 4];
                m_ptr     = (w + 1) % N;
                if (m_cnt[w] < 65535) m_cnt[w]++;
                grant_log.push_back(w);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_op[4*id +: 4]  = op;
    endtask

    // Single transaction with rsp_ready held high: accept, EXEC, RESP handshake
    task automatic txn(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op);
        set_req(id, a, b, op);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        rsp_ready     = 1'b1;
        seen_id       = '1;
        tick();
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    int t3_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        @(posedge clk);
        #1;
        tick();
        tick();

        // Continuous requests from reset: strict rotation
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom, 4'($urandom_range(0, 9)));
        req_valid = '1;
        rsp_ready = 1'b1;
        grant_log.delete();
        for (int i = 0; i < 15; i++) tick();
        for (int i = 0; i < 5; i++)
            check("rotation", (i < grant_log.size()) ? 32'(grant_log[i]) : 32'd99, 32'(t3_exp[i]));
        idle(3);

        // Basic add on requester 0
        txn(0, 32'd5, 32'd7, 4'b0000);
        check("t1_id", seen_id, 32'd0);
        check("t1_result", seen_res, 32'd12);
        check("t1_zero", seen_zero, 32'd0);
        check("t1_err", seen_err, 32'd0);

        // Back-pressured response; other requesters must see no ready
        set_req(2, 32'd3, 32'd3, 4'b0001);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        seen_id   = '1;
        tick();
        req_valid = '1;
        for (int i = 0; i < 5; i++) tick();
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        check("t2_id", seen_id, 32'd2);
        check("t2_result", seen_res, 32'd0);
        check("t2_zero", seen_zero, 32'd1);
        idle(2);

        // Arithmetic shift, then undefined op
        txn(1, 32'h80000000, 32'd1, 4'b0111);
        check("t4_sra", seen_res, 32'hC0000000);
        check("t4_sra_err", seen_err, 32'd0);
        txn(1, 32'h80000000, 32'd1, 4'b1111);
        check("t4_undef", seen_res, 32'hdeadbeef);
        check("t4_undef_err", seen_err, 32'd1);
        check("t4_undef_zero", seen_zero, 32'd0);

        // Reset during EXEC discards the transaction
        set_req(0, 32'd1, 32'd2, 4'b0000);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(4);
        txn(3, 32'd10, 32'd4, 4'b0001);
        check("t5_id", seen_id, 32'd3);
        check("t5_result", seen_res, 32'd6);

`ifdef ALU_ARB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        txn(0, 32'd1, 32'd1, 4'd0);
        txn(0, 32'd1, 32'd1, 4'd0);
        txn(0, 32'd1, 32'd1, 4'd0);
        txn(1, 32'd1, 32'd1, 4'd0);
        tick();
        check("t6_cnt0", 32'(grant_cnt[15:0]), 32'd3);
        check("t6_cnt1", 32'(grant_cnt[31:16]), 32'd1);
        check("t6_cnt2", 32'(grant_cnt[47:32]), 32'd0);
        check("t6_cnt3", 32'(grant_cnt[63:48]), 32'd0);
        rst = 1'b1;
        tick();
        check("t6_cnt_rst", 32'(grant_cnt[31:0]), 32'd0);
        rst = 1'b0;
`endif

        // Randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 0)
                    set_req(i, 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)), 4'($urandom));
                else
                    set_req(i, $urandom, $urandom, 4'($urandom));
            end
            tick();
        end
        rst = 1'b0;
        idle(4);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
